// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues 1-cycle-latency imem reads and
// buffers {pc, insn} pairs for decode behind a valid/ready handshake.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0100_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_insn,
    output logic        fetch_err
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t          state, state_next;
    logic [31:0]     pc_p0;
    logic            vld_p1;
    logic [31:0]     tag_p1;
    logic [31:0]     buf_pc   [BUF_DEPTH];
    logic [31:0]     buf_insn [BUF_DEPTH];
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic [CW-1:0]   occ;
    logic            redirect, pop, push, issue;

    always_ff @(posedge clock) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // Occupancy counts the read in flight so a full buffer can never be overrun.
    always_comb begin
        state_next = state;
        redirect   = 1'b0;
        pop        = 1'b0;
        push       = 1'b0;
        issue      = 1'b0;
        dec_valid  = 1'b0;
        fetch_err  = 1'b0;
        occ        = count;
        case (state)
            RUN: begin
                redirect  = redirect_valid;
                if (redirect_valid && (redirect_pc[1:0] != 2'b00)) state_next = HALT;
                dec_valid = !reset && (count != '0);
                pop       = dec_valid && dec_ready && !redirect;
                push      = vld_p1 && !redirect;
                occ       = count + CW'(vld_p1) - CW'(pop);
                issue     = !reset && !redirect && (occ < DEPTH_C);
            end
            HALT: fetch_err = 1'b1;
            default: state_next = RUN;
        endcase
    end

    assign imem_req  = issue;
    assign imem_addr = pc_p0;
    assign dec_pc    = dec_valid ? buf_pc[head]   : '0;
    assign dec_insn  = dec_valid ? buf_insn[head] : '0;

    // Stage p0 -> p1: PC advance and in-flight tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_p0  <= RESET_PC;
            vld_p1 <= 1'b0;
            count  <= '0;
            head   <= '0;
            tail   <= '0;
        end else begin
            vld_p1 <= issue;
            if (redirect) begin
                pc_p0 <= redirect_pc;
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                if (issue) pc_p0 <= pc_p0 + 32'd4;
                if (push)  tail  <= tail + PW'(1);
                if (pop)   head  <= head + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Stage p1 -> buffer: response capture with its issuing PC
    always_ff @(posedge clock) begin
        tag_p1 <= pc_p0;
        if (push) begin
            buf_pc[tail]   <= tag_p1;
            buf_insn[tail] <= imem_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && state == RUN)
            assert (!(push && !pop && count == DEPTH_C));
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, halt,
// PC wrap and reset mid-operation against hand-computed expectations.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0100_0000;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_insn;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_insn(dec_insn), .fetch_err(fetch_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // imem: word at address a is insn_of(a), returned the cycle after the request
    always @(posedge clock) begin
        if (imem_req) imem_rdata <= insn_of(imem_addr);
    end

    // backpressure table: dec_ready low until cycle 5
    bit          bp_req [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
    logic [31:0] bp_adr [8] = '{32'h0100_0000, 32'h0100_0004, 0, 0, 0,
                                32'h0100_0008, 32'h0100_000C, 32'h0100_0010};
    bit          bp_dv  [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
    logic [31:0] bp_pc  [8] = '{0, 0, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000,
                                32'h0100_0000, 32'h0100_0004, 32'h0100_0008};

    task automatic next_cycle;
        @(posedge clock);
        #2;
    endtask

    task automatic apply_reset(input logic rdy);
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        dec_ready = rdy;
        repeat (2) begin @(posedge clock); #2; end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; dec_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) begin @(posedge clock); #2; end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got=%b exp=0", dec_valid); end
        checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", dec_pc); end
        checks++; if (dec_insn !== 32'h0) begin errors++; $display("FAIL reset_insn got=%h exp=0", dec_insn); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", fetch_err); end
    endtask

    task automatic test_stream;
        logic [31:0] ea, ep;
        apply_reset(1'b1);
        for (int c = 0; c < 8; c++) begin
            ea = RPC + 32'(4 * c);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== ea) begin
                errors++; $display("FAIL stream_issue c=%0d req=%b addr=%h exp=%h", c, imem_req, imem_addr, ea);
            end
            checks++;
            if (c < 2) begin
                if (dec_valid !== 1'b0) begin errors++; $display("FAIL stream_dv c=%0d got=%b exp=0", c, dec_valid); end
            end else begin
                ep = RPC + 32'(4 * (c - 2));
                if (dec_valid !== 1'b1 || dec_pc !== ep || dec_insn !== insn_of(ep)) begin
                    errors++; $display("FAIL stream_dec c=%0d dv=%b pc=%h insn=%h exp pc=%h insn=%h", c, dec_valid, dec_pc, dec_insn, ep, insn_of(ep));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure;
        apply_reset(1'b0);
        for (int c = 0; c < 8; c++) begin
            if (c == 5) begin dec_ready = 1'b1; #1; end
            checks++;
            if (imem_req !== bp_req[c] || (bp_req[c] && imem_addr !== bp_adr[c])) begin
                errors++; $display("FAIL bp_issue c=%0d req=%b addr=%h exp req=%b addr=%h", c, imem_req, imem_addr, bp_req[c], bp_adr[c]);
            end
            checks++;
            if (dec_valid !== bp_dv[c] || (bp_dv[c] && (dec_pc !== bp_pc[c] || dec_insn !== insn_of(bp_pc[c])))) begin
                errors++; $display("FAIL bp_dec c=%0d dv=%b pc=%h exp dv=%b pc=%h", c, dec_valid, dec_pc, bp_dv[c], bp_pc[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_redirect;
        apply_reset(1'b1);
        repeat (4) next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0100_0100; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req got=%b exp=0", imem_req); end
        next_cycle(); redirect_valid = 1'b0; #1;
        checks++;
        if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0100_0100) begin
            errors++; $display("FAIL redir_c5 dv=%b req=%b addr=%h exp dv=0 req=1 addr=01000100", dec_valid, imem_req, imem_addr);
        end
        next_cycle();
        checks++;
        if (dec_valid !== 1'b0 || imem_addr !== 32'h0100_0104) begin
            errors++; $display("FAIL redir_c6 dv=%b addr=%h exp dv=0 addr=01000104", dec_valid, imem_addr);
        end
        next_cycle();
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h0100_0100 || dec_insn !== insn_of(32'h0100_0100)) begin
            errors++; $display("FAIL redir_first dv=%b pc=%h insn=%h exp pc=01000100", dec_valid, dec_pc, dec_insn);
        end
        next_cycle();
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h0100_0104) begin
            errors++; $display("FAIL redir_second dv=%b pc=%h exp pc=01000104", dec_valid, dec_pc);
        end
        next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0100_0200; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL b2b_req1 got=%b exp=0", imem_req); end
        next_cycle();
        redirect_pc = 32'h0100_0300; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL b2b_req2 got=%b exp=0", imem_req); end
        next_cycle(); redirect_valid = 1'b0; #1;
        checks++;
        if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0100_0300) begin
            errors++; $display("FAIL b2b_issue dv=%b req=%b addr=%h exp dv=0 req=1 addr=01000300", dec_valid, imem_req, imem_addr);
        end
        next_cycle();
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL b2b_dv got=%b exp=0", dec_valid); end
        next_cycle();
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h0100_0300) begin
            errors++; $display("FAIL b2b_dec dv=%b pc=%h exp pc=01000300", dec_valid, dec_pc);
        end
        next_cycle();
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h0100_0304) begin
            errors++; $display("FAIL b2b_dec2 dv=%b pc=%h exp pc=01000304", dec_valid, dec_pc);
        end
    endtask

    task automatic test_misaligned;
        apply_reset(1'b1);
        repeat (3) next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0100_0102; #1;
        next_cycle(); redirect_valid = 1'b0; #1;
        for (int c = 4; c < 10; c++) begin
            if (c == 6) begin redirect_valid = 1'b1; redirect_pc = 32'h0100_0400; #1; end
            if (c == 7) begin redirect_valid = 1'b0; #1; end
            checks++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || dec_valid !== 1'b0) begin
                errors++; $display("FAIL halt c=%0d err=%b req=%b dv=%b exp err=1 req=0 dv=0", c, fetch_err, imem_req, dec_valid);
            end
            next_cycle();
        end
        apply_reset(1'b1);
        checks++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RPC) begin
            errors++; $display("FAIL halt_recover err=%b req=%b addr=%h exp err=0 req=1 addr=%h", fetch_err, imem_req, imem_addr, RPC);
        end
        repeat (2) next_cycle();
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== RPC) begin
            errors++; $display("FAIL halt_restart dv=%b pc=%h exp pc=%h", dec_valid, dec_pc, RPC);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] ea, ep;
        apply_reset(1'b1);
        repeat (2) next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; #1;
        next_cycle(); redirect_valid = 1'b0; #1;
        for (int c = 3; c < 8; c++) begin
            ea = 32'hFFFF_FFF8 + 32'(4 * (c - 3));
            checks++;
            if (c < 7 && (imem_req !== 1'b1 || imem_addr !== ea)) begin
                errors++; $display("FAIL wrap_addr c=%0d req=%b addr=%h exp=%h", c, imem_req, imem_addr, ea);
            end
            if (c >= 5) begin
                ep = 32'hFFFF_FFF8 + 32'(4 * (c - 5));
                checks++;
                if (dec_valid !== 1'b1 || dec_pc !== ep || dec_insn !== insn_of(ep)) begin
                    errors++; $display("FAIL wrap_dec c=%0d dv=%b pc=%h exp=%h", c, dec_valid, dec_pc, ep);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid;
        apply_reset(1'b0);
        repeat (2) next_cycle();
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== RPC) begin
            errors++; $display("FAIL mid_pre dv=%b pc=%h exp pc=%h", dec_valid, dec_pc, RPC);
        end
        reset = 1'b1; #1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (imem_req !== 1'b0 || dec_valid !== 1'b0 || dec_pc !== 32'h0) begin
                errors++; $display("FAIL mid_reset c=%0d req=%b dv=%b pc=%h exp 0 0 0", c, imem_req, dec_valid, dec_pc);
            end
            next_cycle();
        end
        reset = 1'b0; dec_ready = 1'b1; #1;
        checks++;
        if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RPC) begin
            errors++; $display("FAIL mid_restart dv=%b req=%b addr=%h exp dv=0 req=1 addr=%h", dec_valid, imem_req, imem_addr, RPC);
        end
        next_cycle();
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL mid_dead dv=%b exp=0", dec_valid); end
        next_cycle();
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== RPC) begin
            errors++; $display("FAIL mid_first dv=%b pc=%h exp=%h", dec_valid, dec_pc, RPC);
        end
        next_cycle();
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== RPC + 32'd4) begin
            errors++; $display("FAIL mid_second dv=%b pc=%h exp=%h", dec_valid, dec_pc, RPC + 32'd4);
        end
    endtask

    initial begin
        imem_rdata = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

endmodule
